// File: rtl/change_dispenser.sv
// Coin payout engine: turns a change amount into a serial stream of ejector coin codes,
// choosing the largest affordable in-stock coin each time.

module change_coin_slot #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr_paid,
  input  logic             take,
  output logic [CNT_W-1:0] inv,
  output logic [CNT_W-1:0] paid
);
  logic [CNT_W-1:0] inv_q, inv_d, paid_q, paid_d;

  always_comb begin
    inv_d  = inv_q;
    paid_d = paid_q;
    if (load)      inv_d = load_val;
    else if (take) inv_d = inv_q - CNT_W'(1);
    if (clr_paid)  paid_d = '0;
    else if (take) paid_d = paid_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_q  <= '0;
      paid_q <= '0;
    end else begin
      inv_q  <= inv_d;
      paid_q <= paid_d;
    end
  end

  assign inv  = inv_q;
  assign paid = paid_q;
endmodule

module change_dispenser #(
  parameter int AMT_W = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             load_inv,
  input  logic [CNT_W-1:0] inv_nickel,
  input  logic [CNT_W-1:0] inv_dime,
  input  logic [CNT_W-1:0] inv_quarter,
  input  logic [CNT_W-1:0] inv_half,
  input  logic [CNT_W-1:0] inv_dollar,
  input  logic             coin_ready,
  output logic             coin_valid,
  output logic [2:0]       coin_code,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [CNT_W-1:0] nickelct,
  output logic [CNT_W-1:0] dimect,
  output logic [CNT_W-1:0] quarterct,
  output logic [CNT_W-1:0] half_dollarct,
  output logic [CNT_W-1:0] dollarct,
  output logic [CNT_W-1:0] nickel_out,
  output logic [CNT_W-1:0] dime_out,
  output logic [CNT_W-1:0] quarter_out,
  output logic [CNT_W-1:0] half_dollar_out,
  output logic [CNT_W-1:0] dollar_out
);
  localparam int NUM_COINS = 5;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE} state_e;

  state_e                            state_q, state_d;
  logic [AMT_W-1:0]                  remaining_q, remaining_d;
  logic                              short_q, short_d;
  logic [2:0]                        sel_q, sel_d;
  logic                              load_en, clr_out;
  logic [NUM_COINS-1:0]              take;
  logic [NUM_COINS-1:0][CNT_W-1:0]   load_vals, inv, paid;

  // Slot index 0..4 = nickel..dollar; coin code is index+1.
  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] idx);
    case (idx)
      3'd0:    coin_value = AMT_W'(1);
      3'd1:    coin_value = AMT_W'(2);
      3'd2:    coin_value = AMT_W'(5);
      3'd3:    coin_value = AMT_W'(10);
      3'd4:    coin_value = AMT_W'(20);
      default: coin_value = '0;
    endcase
  endfunction

  assign load_vals = {inv_dollar, inv_half, inv_quarter, inv_dime, inv_nickel};

  always_comb begin
    logic       found;
    logic [2:0] best;
    state_d     = state_q;
    remaining_d = remaining_q;
    short_d     = short_q;
    sel_d       = sel_q;
    load_en     = 1'b0;
    clr_out     = 1'b0;
    take        = '0;
    found       = 1'b0;
    best        = '0;
    // Ascending scan so the largest qualifying coin wins.
    for (int i = 0; i < NUM_COINS; i++) begin
      if (inv[i] != '0 && coin_value(3'(i)) <= remaining_q) begin
        found = 1'b1;
        best  = 3'(i);
      end
    end
    case (state_q)
      S_IDLE: begin
        load_en = load_inv;
        if (start) begin
          remaining_d = amount;
          short_d     = 1'b0;
          clr_out     = 1'b1;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if (found) begin
          sel_d   = best;
          state_d = S_ISSUE;
        end else begin
          short_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ISSUE: begin
        if (coin_ready) begin
          take[sel_q] = 1'b1;
          remaining_d = remaining_q - coin_value(sel_q);
          state_d     = S_SELECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      short_q     <= 1'b0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      short_q     <= short_d;
      sel_q       <= sel_d;
    end
  end

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_slot
    change_coin_slot #(.CNT_W(CNT_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load_en),
      .load_val (load_vals[g]),
      .clr_paid (clr_out),
      .take     (take[g]),
      .inv      (inv[g]),
      .paid     (paid[g])
    );
  end

  assign coin_valid      = (state_q == S_ISSUE);
  assign coin_code       = coin_valid ? (sel_q + 3'd1) : 3'd0;
  assign busy            = (state_q == S_SELECT) || (state_q == S_ISSUE);
  assign done            = (state_q == S_DONE);
  assign short           = short_q;
  assign remaining       = remaining_q;
  assign nickelct        = inv[0];
  assign dimect          = inv[1];
  assign quarterct       = inv[2];
  assign half_dollarct   = inv[3];
  assign dollarct        = inv[4];
  assign nickel_out      = paid[0];
  assign dime_out        = paid[1];
  assign quarter_out     = paid[2];
  assign half_dollar_out = paid[3];
  assign dollar_out      = paid[4];
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Payout side of the vending machine's coin interface. The acceptor decodes inserted coins into 3-bit codes; this block does the reverse.
- Given a change/refund amount, it serially issues coin codes to the coin-ejector mechanism using a valid/ready handshake.
- Greedy largest-coin-first selection, bounded by a per-denomination inventory it maintains.
- Sits between the vending FSM (start/amount/done) and the ejector hardware.

Parameters:
- AMT_W, 8, width of amount/remaining, in nickel units (1 = 5 cents).
- CNT_W, 5, width of inventory and per-transaction payout counters.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- amount  input  AMT_W  change to pay in nickel units; latched with start.
- load_inv  input  1  load inventory from inv_* inputs; honoured only in IDLE.
- inv_nickel, inv_dime, inv_quarter, inv_half, inv_dollar  input  CNT_W each  inventory load values.
- coin_ready  input  1  ejector accepts the presented coin this cycle.
- coin_valid  output  1  coin_code is valid.
- coin_code  output  3  coin code: 001 nickel, 010 dime, 011 quarter, 100 half-dollar, 101 dollar, 000 none.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle completion pulse.
- short  output  1  with done: exact change could not be paid; held until next start.
- remaining  output  AMT_W  unpaid amount; after done, the shortfall.
- nickelct, dimect, quarterct, half_dollarct, dollarct  output  CNT_W each  current inventory.
- nickel_out, dime_out, quarter_out, half_dollar_out, dollar_out  output  CNT_W each  coins paid in the current/last transaction.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0, including coin_code=000, all inventory counts and all *_out counts.
- Coin values in nickel units: dollar=20, half=10, quarter=5, dime=2, nickel=1.
- States:
  - IDLE: load_inv=1 copies the inv_* inputs to the inventory registers next edge. start=1 latches amount into remaining, clears the *_out counters and short, then goes to SELECT. If start and load_inv are both high, the load happens and start is also taken.
  - SELECT (1 cycle):
    - remaining==0 -> DONE with short=0.
    - Otherwise pick the largest denomination with value <= remaining and inventory > 0, then go to ISSUE.
    - If no denomination qualifies -> DONE with short=1.
  - ISSUE: coin_valid=1 and coin_code is held stable until a cycle with coin_ready=1. On that edge:
    - decrement that inventory;
    - increment the matching *_out;
    - subtract the coin value from remaining;
    - coin_valid drops to 0 and state goes to SELECT.
  - DONE: done=1 for exactly one cycle, busy=0 in this cycle, then IDLE.
- Latency: start at edge N -> coin_valid first high after edge N+2. Each accepted coin costs at least 2 cycles (ISSUE, then SELECT).
- The handshake does not time out; coin_ready held low keeps ISSUE indefinitely.
- coin_ready while coin_valid=0 is ignored.
- start or load_inv while busy is ignored, including in DONE.
- No arithmetic overflow by construction:
  - remaining never goes negative because of the selection rule;
  - *_out never exceeds the starting inventory (max 31).
- Greedy with depleted stock may leave an odd remainder (e.g. remaining=3 with dimes but no nickels -> one dime, short=1, remaining=1). This is required behaviour, not an error.
- A reset mid-transaction aborts immediately; a coin presented but not yet accepted is not counted.

Test Plan:
1. Inventory all 10, amount=7 (35c) -> quarter then dime; quarter_out=1, dime_out=1; remaining=0; short=0; done pulses once; quartct=9, dimect=9.
2. Inventory all 10, amount=50 ($2.50), coin_ready always 1 -> coin_codes 101,101,100; dollar_out=2, half_dollar_out=1; first coin_valid 2 cycles after start; coins spaced 2 cycles apart.
3. Backpressure: amount=1, coin_ready low for 5 cycles then high -> coin_code=001 held stable for all 6 valid cycles; nickelct decrements exactly once.
4. Shortage: nickels=0, dimes=1, others 0, amount=3 -> one dime issued, then done with short=1, remaining=1.
5. amount=0 -> done 2 cycles after start, no coin_valid, short=0. Additionally, start pulsed while busy -> ignored; *_out counts unchanged.
6. Assert rst while in ISSUE -> all outputs 0 at once, including inventory. Then load_inv with start in the same cycle -> new inventory is used for that transaction.
